// File: rtl/jtopl_reg_wr_sched.sv
// Register write scheduler: queues host writes and merges each one into the channel ring when its channel passes.
// Optional JTOPL_WRSCHED_STATS_EN adds drop_cnt, a saturating count of discarded/rejected requests.
module jtopl_reg_wr_sched #(
    parameter int CHCSRW     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              wr_req,
    input  logic [3:0]        wr_ch,
    input  logic [CHCSRW-1:0] wr_data,
    input  logic [CHCSRW-1:0] wr_mask,
    output logic              wr_ack,
    output logic              full,
    input  logic [CHCSRW-1:0] chcfg,
    output logic [CHCSRW-1:0] chcfg_inmux,
    output logic [1:0]        group,
    output logic [17:0]       slot,
    output logic              zero,
`ifdef JTOPL_WRSCHED_STATS_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic [3:0]        ch_cur
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int AD = 1 << PW;

    logic [4:0]        slot_idx;
    logic [3:0]        q_ch   [AD];
    logic [CHCSRW-1:0] q_data [AD];
    logic [CHCSRW-1:0] q_mask [AD];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [2:0]        count;
    logic              empty;
    logic              ch_bad;
    logic              commit;
    logic              push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ring position counters, all stepping together on cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_idx <= '0;
            group    <= '0;
            ch_cur   <= '0;
        end else if (cen) begin
            slot_idx <= (slot_idx == 5'd17) ? 5'd0 : slot_idx + 5'd1;
            group    <= (group == 2'd2) ? 2'd0 : group + 2'd1;
            ch_cur   <= (ch_cur == 4'd8) ? 4'd0 : ch_cur + 4'd1;
        end
    end

    assign slot = 18'd1 << slot_idx;
    assign zero = (slot_idx == 5'd0);

    assign empty  = (count == 3'd0);
    assign full   = (count == 3'(FIFO_DEPTH));
    assign commit = cen && !empty && (q_ch[rd_ptr] == ch_cur);
    assign ch_bad = (wr_ch > 4'd8);
    // A full queue can still take a request when the head leaves this cycle
    assign wr_ack = !rst && wr_req && (ch_bad || !full || commit);
    assign push   = wr_ack && !ch_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (commit)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, commit})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_ch[wr_ptr]   <= wr_ch;
            q_data[wr_ptr] <= wr_data;
            q_mask[wr_ptr] <= wr_mask;
        end
    end

    assign chcfg_inmux = commit
        ? ((chcfg & ~q_mask[rd_ptr]) | (q_data[rd_ptr] & q_mask[rd_ptr]))
        : chcfg;

`ifdef JTOPL_WRSCHED_STATS_EN
    logic drop;

    assign drop = !rst && wr_req && (ch_bad || (full && !commit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule
